fmult_unit: RTL and testbench



---
 rtl/fmult_pkg.sv | 43 ++++
 rtl/fx_saturate.sv | 40 ++++
 rtl/fmult_unit.sv | 46 ++++
 tb/tb_fmult_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fmult_pkg.sv
// Shared constants and helpers for the fixed-point multiply/add datapath.
// Saturation bounds are returned sign-extended to 64 bits so callers can narrow them with a width cast.
package fmult_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_FRAC  = 7;

    // Largest positive value of a width-bit two's-complement number: 0111...1
    function automatic logic [63:0] sat_max(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Most negative value of a width-bit two's-complement number: 1000...0
    function automatic logic [63:0] sat_min(input int width);
        logic [63:0] v;
        v = '1;
        for (int i = 0; i < 64; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Converts a real value to Q-format bits with frac fractional bits.
    // This is for building constants in benches only; it is not synthesizable.
    function automatic logic [63:0] q_from_real(input real value, input int frac);
        real scaled;
        scaled = value;
        for (int i = 0; i < frac; i++) begin
            scaled = scaled * 2.0;
        end
        return 64'(longint'(scaled));
    endfunction

endpackage

// File: rtl/fx_saturate.sv
// Generic signed narrowing saturator: clamps an IN_W-bit value into OUT_W bits.
// sat is high whenever the input could not be represented and was clamped.
module fx_saturate
    import fmult_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // Bits from the output sign position upward must all match the input sign.
    localparam int HI_W = IN_W - OUT_W + 1;
    localparam logic [OUT_W-1:0] MAX_VAL = OUT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0] MIN_VAL = OUT_W'(sat_min(OUT_W));

    logic [HI_W-1:0] hi_agree;
    logic            fits;

    genvar gi;
    generate
        for (gi = 0; gi < HI_W; gi++) begin : g_agree
            assign hi_agree[gi] = din[OUT_W-1+gi] ~^ din[IN_W-1];
        end
    endgenerate

    assign fits = &hi_agree;

    always_comb begin
        result = din[OUT_W-1:0];
        sat    = 1'b0;
        if (!fits) begin
            sat    = 1'b1;
            result = din[IN_W-1] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/fmult_unit.sv
// Signed Q-format multiplier: exact product, floor rescale, saturate, one register stage.
// o_ovr chains the upstream overflow flag with this stage's saturation, per sample.
module fmult_unit
    import fmult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [WIDTH-1:0] i_multiplicand,
    input  logic signed [WIDTH-1:0] i_multiplier,
    input  logic                    i_ovr,
    output logic signed [WIDTH-1:0] o_result,
    output logic                    o_ovr
);

    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] scaled;
    logic signed [WIDTH-1:0]   sat_result;
    logic                      sat_flag;

    // Full-width product is exact, so min*min lands as +2^(2W-2) and saturates instead of wrapping.
    assign product = i_multiplicand * i_multiplier;
    assign scaled  = product >>> FRAC;

    fx_saturate #(
        .IN_W  (2 * WIDTH),
        .OUT_W (WIDTH)
    ) u_saturate (
        .din    (scaled),
        .result (sat_result),
        .sat    (sat_flag)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result <= '0;
            o_ovr    <= 1'b0;
        end else begin
            o_result <= sat_result;
            o_ovr    <= i_ovr | sat_flag;
        end
    end

endmodule

// File: tb/tb_fmult_unit.sv
// Self-checking bench for fmult_unit (WIDTH=16, FRAC=7): directed literals plus a random stream vs. an integer model.
`timescale 1ns/1ps
module tb_fmult_unit;
    import fmult_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_multiplicand;
    logic [15:0] i_multiplier;
    logic        i_ovr;
    logic [15:0] o_result;
    logic        o_ovr;

    int checks   = 0;
    int failures = 0;

    bit          model_valid = 1'b0;
    logic [15:0] exp_r;
    logic        exp_o;

    int          lit_seq  = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [15:0] lit_r;
    logic        lit_o;

    fmult_unit #(.WIDTH(16), .FRAC(7)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .i_ovr          (i_ovr),
        .o_result       (o_result),
        .o_ovr          (o_ovr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference: exact integer product, floor division by 2^7, clamp to 16-bit signed range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ovr,
                         output logic [15:0] r, output logic o);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = p >>> 7;
        if (s > 32767) begin
            r = 16'h7FFF; o = 1'b1;
        end else if (s < -32768) begin
            r = 16'h8000; o = 1'b1;
        end else begin
            r = 16'(s); o = 1'b0;
        end
        o = o | ovr;
    endtask

    task automatic check(input string name, input logic [15:0] act_r, input logic [15:0] req_r,
                         input logic act_o, input logic req_o);
        checks++;
        if (act_r !== req_r || act_o !== req_o) begin
            failures++;
            $display("FAIL %s: got result=%h ovr=%b, expected result=%h ovr=%b at %0t",
                     name, act_r, act_o, req_r, req_o, $time);
        end
    endtask

    always @(posedge i_clk) begin
        if (i_rst) begin
            model_valid = 1'b0;
        end else begin
            model(i_multiplicand, i_multiplier, i_ovr, exp_r, exp_o);
            model_valid = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (i_rst) begin
            check("reset", o_result, 16'h0000, o_ovr, 1'b0);
        end else begin
            if (model_valid) begin
                check("model", o_result, exp_r, o_ovr, exp_o);
            end
            if (lit_seq != lit_done) begin
                check(lit_name, o_result, lit_r, o_ovr, lit_o);
                lit_done = lit_seq;
            end
        end
    end

    // Drives one vector; its literal expectation is checked after the capturing edge.
    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic ovr, input logic [15:0] er, input logic eo);
        i_multiplicand = a;
        i_multiplier   = b;
        i_ovr          = ovr;
        @(posedge i_clk);
        #1;
        lit_name = name;
        lit_r    = er;
        lit_o    = eo;
        lit_seq++;
    endtask

    logic [15:0] edge_vals [6] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0080, 16'hFF80};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 7) == 0) begin
            return edge_vals[$urandom_range(0, 5)];
        end
        return 16'($urandom);
    endfunction

    initial begin
        i_rst          = 1'b1;
        i_multiplicand = 16'h1234;
        i_multiplier   = 16'h5678;
        i_ovr          = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        apply("one_x_one",   16'h0080, 16'h0080, 1'b0, 16'h0080, 1'b0);
        apply("2p5_x_m1p5",  16'(q_from_real(2.5, 7)), 16'(q_from_real(-1.5, 7)), 1'b0, 16'hFE20, 1'b0);
        apply("trunc_pos",   16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0);
        apply("trunc_neg",   16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b0);
        apply("sat_pos",     16'h6400, 16'h0100, 1'b0, 16'h7FFF, 1'b1);
        apply("sat_neg",     16'h9C00, 16'h0100, 1'b0, 16'h8000, 1'b1);
        apply("min_x_min",   16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
        apply("max_x_max",   16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
        apply("neg_one_sq",  16'hFF80, 16'hFF80, 1'b0, 16'h0080, 1'b0);
        apply("chain_in",    16'h0080, 16'h0080, 1'b1, 16'h0080, 1'b1);
        apply("chain_clear", 16'h0080, 16'h0080, 1'b0, 16'h0080, 1'b0);

        // Mid-stream asynchronous reset: outputs hold 0x0080 until i_rst rises between edges.
        @(posedge i_clk);
        #1;
        i_multiplicand = 16'h1234;
        i_multiplier   = 16'h5678;
        i_ovr          = 1'b1;
        i_rst          = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        apply("post_reset",  16'h0100, 16'h0180, 1'b0, 16'h0300, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            i_multiplicand = pick();
            i_multiplier   = pick();
            i_ovr          = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1;
        end

        @(negedge i_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
